// File: rtl/vram_arbiter.sv
// Arbitrates one single-port synchronous VRAM between scanout fetches (absolute priority)
// and the JML-8 CPU bus (posted-write FIFO, ordered reads). Optional macro: VRAM_ARB_STATS_EN.
module vram_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic { ST_IDLE, ST_ACK } cpu_state_e;
  typedef enum logic [1:0] { OWN_NONE, OWN_DISP, OWN_CPU } owner_e;

  cpu_state_e state_q, state_d;
  owner_e     owner_q, owner_d;

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  logic fifo_empty, fifo_full;
  logic push, rd_issue, drain;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

  // Grant and CPU next-state; gated by rst_n so the RAM port is quiet while in reset.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    owner_d   = OWN_NONE;
    push      = 1'b0;
    rd_issue  = 1'b0;
    drain     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (rst_n) begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_req && cpu_we && !fifo_full) begin
            push    = 1'b1;
            state_d = ST_ACK;
          end else if (cpu_req && !cpu_we && fifo_empty && !disp_req) begin
            rd_issue = 1'b1;
            state_d  = ST_ACK;
          end
        end
        ST_ACK: state_d = ST_IDLE;
      endcase

      // A read only issues on an empty FIFO, so it never competes with a drain.
      drain = !fifo_empty && !disp_req && !rd_issue;

      if (disp_req) begin
        mem_re   = 1'b1;
        mem_addr = disp_addr;
        owner_d  = OWN_DISP;
      end else if (rd_issue) begin
        mem_re   = 1'b1;
        mem_addr = cpu_addr;
        owner_d  = OWN_CPU;
      end else if (drain) begin
        mem_we    = 1'b1;
        mem_addr  = fifo_addr[rd_ptr_q[IDX_W-1:0]];
        mem_wdata = fifo_data[rd_ptr_q[IDX_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (push)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (drain) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (owner_q == OWN_CPU) rdata_q <= mem_rdata;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q[IDX_W-1:0]] <= cpu_addr;
      fifo_data[wr_ptr_q[IDX_W-1:0]] <= cpu_wdata;
    end
  end

  // Owner tag steers the RAM's one-cycle-late read data to its requester.
  assign disp_valid = (owner_q == OWN_DISP);
  assign disp_data  = (owner_q == OWN_DISP) ? mem_rdata : '0;
  assign cpu_ack    = (state_q == ST_ACK);
  assign cpu_rdata  = (owner_q == OWN_CPU) ? mem_rdata : rdata_q;

`ifdef VRAM_ARB_STATS_EN
  logic stall;
  assign stall = (state_q == ST_IDLE) && cpu_req && !push && !rd_issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stats_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
